parking_zone_ctrl: RTL and testbench
====================================

PARKING_ZONE_CTRL -- requirements
Module: parking_zone_ctrl

Interface
REQ-001 Parameter N_ZONES, default 2, number of parking zones; zone 0 = university, zone 1 = public, zones 2..N-1 = auxiliary.
REQ-002 Parameter CNT_W, default 16, width of every occupancy and vacancy count.
REQ-003 Parameter HOUR_W, default 12, width of the hour input.
REQ-004 Parameter MAX_CAP, default 700, global limit on total occupancy across all zones.
REQ-005 Parameter AUX_CAP, default 0, fixed capacity of every auxiliary zone during open hours.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 start  in  1  asynchronous active-low reset: start=0 clears all state immediately; start=1 means run.
REQ-008 hour  in  HOUR_W  current hour from the external timer.
REQ-009 ent_valid  in  1  entry request strobe; ent_zone  in  ZW=max(1,$clog2(N_ZONES))  target zone.
REQ-010 ext_valid  in  1  exit request strobe; ext_zone  in  ZW  source zone.
REQ-011 ent_ack / ent_nack  out  1 each  entry accepted / rejected, one-cycle pulse.
REQ-012 ext_ack / ext_nack  out  1 each  exit accepted / rejected, one-cycle pulse.
REQ-013 occupied  out  N_ZONES*CNT_W  per-zone parked count, zone 0 in LSBs.
REQ-014 vacant  out  N_ZONES*CNT_W  per-zone free spaces; zone_avail  out  N_ZONES  per-zone vacant != 0.
REQ-015 total_occ  out  CNT_W  sum of occupied; reject_cnt  out  CNT_W  rejected entries; state  out  2  FSM state.

Function
REQ-016 hour SHALL be registered into hour_q each cycle; capacities SHALL derive only from hour_q, one cycle after hour changes.
REQ-017 Capacity SHALL come from bands on hour_q: <8 all 0; 8-12 z0=500 z1=200; 13 z0=450 z1=250; 14 z0=400 z1=300; 15 z0=350 z1=350; >=16 z0=200 z1=500; auxiliary zones AUX_CAP when hour_q>=8, else 0.
REQ-018 FSM states: CLOSED(00), OPEN(01), FULL(10); CLOSED when hour_q<8; OPEN when hour_q>=8 and total_occ<MAX_CAP; FULL when hour_q>=8 and total_occ>=MAX_CAP; re-evaluated every cycle.
REQ-019 Entry SHALL be accepted only when state=OPEN, ent_zone<N_ZONES, occupied[z]<cap[z] and total_occ<MAX_CAP, all evaluated on pre-edge values.
REQ-020 Exit SHALL be accepted when ext_zone<N_ZONES and occupied[z]>0, in any state, including CLOSED.
REQ-021 Accepted entry increments occupied[z] by 1; accepted exit decrements by 1; effect visible after the sampling edge.
REQ-022 ack/nack SHALL be registered, asserted for exactly the one cycle after the sampling edge; exactly one of ack/nack per valid strobe, none without strobe.
REQ-023 Simultaneous entry and exit SHALL both be evaluated on pre-edge state; same-zone entry into a full zone is rejected even with a concurrent accepted exit; if both accepted on the same zone, occupied is unchanged.
REQ-024 vacant[z] SHALL be cap[z]-occupied[z], saturating at 0 when capacity drops below occupancy; no car is evicted.
REQ-025 reject_cnt SHALL increment on each ent_nack and saturate at 2^CNT_W-1.
REQ-026 total_occ SHALL be maintained as a register updated with net change, equal to the sum of occupied at all times.

Reset
REQ-027 While start=0: occupied, total_occ, reject_cnt, hour_q = 0; all ack/nack = 0; state = CLOSED; vacant = 0; zone_avail = 0.
REQ-028 start deassertion mid-traffic SHALL discard in-flight requests; first request is evaluated at the first rising edge with start=1.

Structure
REQ-029 Shared package parking_pkg SHALL hold band boundaries, per-band z0/z1 capacities, state enum type and a capacity-lookup function of (zone, hour).
REQ-030 One sub-module zone_counter (one per zone, generate loop) SHALL hold a single zone's occupancy with inc/dec/cap inputs and vacant/avail outputs.

Verification
REQ-031 start=0 pulse, then hour=7, entry z0 -> ent_nack, occupied[0]=0, state=CLOSED, reject_cnt=1.
REQ-032 hour=9, 200 entries z1 then one more -> 200 ent_ack, 201st ent_nack, vacant[1]=0, zone_avail[1]=0.
REQ-033 hour=9, z0=500 + z1=200 filled, entry z0 -> state=FULL, ent_nack; exit z1 -> ext_ack, state=OPEN next cycle.
REQ-034 hour=9, z0=450 parked, hour->16 -> after one cycle vacant[0]=0, occupied[0]=450; exit z0 -> occupied[0]=449, vacant[0]=0.
REQ-035 z1 full at 200, same-cycle entry z1 + exit z1 -> ent_nack, ext_ack, occupied[1]=199.
REQ-036 Exit from empty zone, and entry/exit with zone id >= N_ZONES (N_ZONES=3) -> nack, counts unchanged.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared definitions for the parking zone controller: opening-hour band
// boundaries, per-band capacities of the university and public zones, the
// controller state type and the capacity lookup used by every zone.
package parking_pkg;

    localparam int unsigned HOUR_OPEN = 8;
    localparam int unsigned HOUR_B13  = 13;
    localparam int unsigned HOUR_B14  = 14;
    localparam int unsigned HOUR_B15  = 15;
    localparam int unsigned HOUR_B16  = 16;

    localparam int unsigned CAP_Z0_B08 = 500;
    localparam int unsigned CAP_Z1_B08 = 200;
    localparam int unsigned CAP_Z0_B13 = 450;
    localparam int unsigned CAP_Z1_B13 = 250;
    localparam int unsigned CAP_Z0_B14 = 400;
    localparam int unsigned CAP_Z1_B14 = 300;
    localparam int unsigned CAP_Z0_B15 = 350;
    localparam int unsigned CAP_Z1_B15 = 350;
    localparam int unsigned CAP_Z0_B16 = 200;
    localparam int unsigned CAP_Z1_B16 = 500;

    typedef enum logic [1:0] {
        ST_CLOSED = 2'b00,
        ST_OPEN   = 2'b01,
        ST_FULL   = 2'b10
    } park_state_t;

    // Capacity of one zone at a given hour; zones 2 and up are auxiliary.
    function automatic int unsigned cap_lookup(input int unsigned zone,
                                               input int unsigned hour,
                                               input int unsigned aux_cap);
        int unsigned z0;
        int unsigned z1;
        int unsigned result;
        if (hour < HOUR_B13) begin
            z0 = CAP_Z0_B08;
            z1 = CAP_Z1_B08;
        end else if (hour < HOUR_B14) begin
            z0 = CAP_Z0_B13;
            z1 = CAP_Z1_B13;
        end else if (hour < HOUR_B15) begin
            z0 = CAP_Z0_B14;
            z1 = CAP_Z1_B14;
        end else if (hour < HOUR_B16) begin
            z0 = CAP_Z0_B15;
            z1 = CAP_Z1_B15;
        end else begin
            z0 = CAP_Z0_B16;
            z1 = CAP_Z1_B16;
        end
        if (hour < HOUR_OPEN) begin
            result = 0;
        end else if (zone >= 2) begin
            result = aux_cap;
        end else if (zone == 0) begin
            result = z0;
        end else begin
            result = z1;
        end
        return result;
    endfunction

endpackage

// File: rtl/zone_counter.sv
// Occupancy counter for a single parking zone. Vacancy saturates at zero when
// the capacity drops below the number of parked cars; nobody is evicted.
module zone_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             start,
    input  logic             inc,
    input  logic             dec,
    input  logic [CNT_W-1:0] cap,
    output logic [CNT_W-1:0] occupied,
    output logic [CNT_W-1:0] vacant,
    output logic             avail
);

    // Count parked cars; simultaneous entry and exit cancel out.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            occupied <= '0;
        end else if (inc && !dec) begin
            occupied <= occupied + CNT_W'(1);
        end else if (dec && !inc) begin
            occupied <= occupied - CNT_W'(1);
        end
    end

    // Free spaces, clamped at zero.
    always_comb begin
        vacant = '0;
        if (cap > occupied) begin
            vacant = cap - occupied;
        end
        avail = (vacant != '0);
    end

endmodule

// File: rtl/parking_zone_ctrl.sv
// Multi-zone parking controller: hour-banded capacities, entry/exit
// arbitration on pre-edge state, global occupancy limit and reject counting.
module parking_zone_ctrl
    import parking_pkg::*;
#(
    parameter int unsigned N_ZONES = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned HOUR_W  = 12,
    parameter int unsigned MAX_CAP = 700,
    parameter int unsigned AUX_CAP = 0,
    localparam int unsigned ZW     = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
    input  logic                     clk,
    input  logic                     start,
    input  logic [HOUR_W-1:0]        hour,
    input  logic                     ent_valid,
    input  logic [ZW-1:0]            ent_zone,
    input  logic                     ext_valid,
    input  logic [ZW-1:0]            ext_zone,
    output logic                     ent_ack,
    output logic                     ent_nack,
    output logic                     ext_ack,
    output logic                     ext_nack,
    output logic [N_ZONES*CNT_W-1:0] occupied,
    output logic [N_ZONES*CNT_W-1:0] vacant,
    output logic [N_ZONES-1:0]       zone_avail,
    output logic [CNT_W-1:0]         total_occ,
    output logic [CNT_W-1:0]         reject_cnt,
    output logic [1:0]               state
);

    logic [HOUR_W-1:0]  hour_q;
    logic [CNT_W-1:0]   cap [N_ZONES];
    logic [CNT_W-1:0]   occ [N_ZONES];
    logic [N_ZONES-1:0] ent_hit;
    logic [N_ZONES-1:0] ext_hit;
    logic [N_ZONES-1:0] room;
    logic [N_ZONES-1:0] nonempty;
    logic [N_ZONES-1:0] inc;
    logic [N_ZONES-1:0] dec;
    logic               ent_ok;
    logic               ext_ok;
    logic [CNT_W-1:0]   total_nxt;
    park_state_t        state_q;
    park_state_t        state_nxt;

    for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
        assign cap[z]      = CNT_W'(cap_lookup(z, 32'(hour_q), AUX_CAP));
        assign ent_hit[z]  = ent_valid && (ent_zone == ZW'(z));
        assign ext_hit[z]  = ext_valid && (ext_zone == ZW'(z));
        assign room[z]     = (occ[z] < cap[z]);
        assign nonempty[z] = (occ[z] != '0);
        assign inc[z]      = ent_hit[z] && ent_ok;
        assign dec[z]      = ext_hit[z] && ext_ok;

        zone_counter #(
            .CNT_W (CNT_W)
        ) u_zone (
            .clk      (clk),
            .start    (start),
            .inc      (inc[z]),
            .dec      (dec[z]),
            .cap      (cap[z]),
            .occupied (occ[z]),
            .vacant   (vacant[z*CNT_W +: CNT_W]),
            .avail    (zone_avail[z])
        );

        assign occupied[z*CNT_W +: CNT_W] = occ[z];
    end

    // An out-of-range zone id matches no zone, so it can never be accepted.
    assign ent_ok = (state_q == ST_OPEN) && (32'(total_occ) < MAX_CAP) && |(ent_hit & room);
    assign ext_ok = |(ext_hit & nonempty);
    assign state  = state_q;

    // Net occupancy change and next state. The state register is loaded from
    // the values hour_q and total_occ take at the same edge, so it always
    // agrees with the currently visible hour_q and total_occ.
    always_comb begin
        total_nxt = total_occ;
        if (ent_ok && !ext_ok) begin
            total_nxt = total_occ + CNT_W'(1);
        end else if (ext_ok && !ent_ok) begin
            total_nxt = total_occ - CNT_W'(1);
        end
        state_nxt = ST_CLOSED;
        if (32'(hour) >= HOUR_OPEN) begin
            state_nxt = (32'(total_nxt) >= MAX_CAP) ? ST_FULL : ST_OPEN;
        end
    end

    // Registered hour, totals, state and one-cycle response pulses.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            hour_q     <= '0;
            total_occ  <= '0;
            reject_cnt <= '0;
            state_q    <= ST_CLOSED;
            ent_ack    <= 1'b0;
            ent_nack   <= 1'b0;
            ext_ack    <= 1'b0;
            ext_nack   <= 1'b0;
        end else begin
            hour_q    <= hour;
            total_occ <= total_nxt;
            state_q   <= state_nxt;
            ent_ack   <= ent_valid && ent_ok;
            ent_nack  <= ent_valid && !ent_ok;
            ext_ack   <= ext_ok;
            ext_nack  <= ext_valid && !ext_ok;
            if (ent_valid && !ent_ok && (reject_cnt != '1)) begin
                reject_cnt <= reject_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_parking_zone_ctrl.sv
// Bench for parking_zone_ctrl with three zones (one auxiliary zone).
module tb_parking_zone_ctrl;

    localparam int unsigned NZ   = 3;
    localparam int unsigned CW   = 16;
    localparam int unsigned HW   = 12;
    localparam int          MAXC = 700;
    localparam int          AUXC = 4;

    logic              clk       = 1'b0;
    logic              start     = 1'b0;
    logic [HW-1:0]     hour      = '0;
    logic              ent_valid = 1'b0;
    logic [1:0]        ent_zone  = '0;
    logic              ext_valid = 1'b0;
    logic [1:0]        ext_zone  = '0;
    logic              ent_ack, ent_nack, ext_ack, ext_nack;
    logic [NZ*CW-1:0]  occupied, vacant;
    logic [NZ-1:0]     zone_avail;
    logic [CW-1:0]     total_occ, reject_cnt;
    logic [1:0]        state;

    parking_zone_ctrl #(
        .N_ZONES (NZ),
        .CNT_W   (CW),
        .HOUR_W  (HW),
        .MAX_CAP (MAXC),
        .AUX_CAP (AUXC)
    ) dut (
        .clk        (clk),
        .start      (start),
        .hour       (hour),
        .ent_valid  (ent_valid),
        .ent_zone   (ent_zone),
        .ext_valid  (ext_valid),
        .ext_zone   (ext_zone),
        .ent_ack    (ent_ack),
        .ent_nack   (ent_nack),
        .ext_ack    (ext_ack),
        .ext_nack   (ext_nack),
        .occupied   (occupied),
        .vacant     (vacant),
        .zone_avail (zone_avail),
        .total_occ  (total_occ),
        .reject_cnt (reject_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_occ [NZ];
    int m_hq;
    int m_rej;
    int m_eack, m_enack, m_xack, m_xnack;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    bit chk_en   = 1'b0;

    function automatic int cap_of(int z, int h);
        if (h < 8)   return 0;
        if (z >= 2)  return AUXC;
        if (h <= 12) return (z == 0) ? 500 : 200;
        if (h == 13) return (z == 0) ? 450 : 250;
        if (h == 14) return (z == 0) ? 400 : 300;
        if (h == 15) return 350;
        return (z == 0) ? 200 : 500;
    endfunction

    function automatic int m_total();
        int s = 0;
        for (int z = 0; z < NZ; z++) s += m_occ[z];
        return s;
    endfunction

    function automatic int m_state();
        if (m_hq < 8) return 0;
        return (m_total() >= MAXC) ? 2 : 1;
    endfunction

    function automatic int m_vac(int z);
        int c = cap_of(z, m_hq);
        return (c > m_occ[z]) ? c - m_occ[z] : 0;
    endfunction

    function automatic int d_occ(int z);
        return int'(occupied[z*CW +: CW]);
    endfunction

    function automatic int d_vac(int z);
        return int'(vacant[z*CW +: CW]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cycle, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < NZ; z++) m_occ[z] = 0;
        m_hq = 0; m_rej = 0;
        m_eack = 0; m_enack = 0; m_xack = 0; m_xnack = 0;
    endtask

    // One clock edge of the rules, all decisions on pre-edge values.
    task automatic model_step();
        int ez = int'(ent_zone);
        int xz = int'(ext_zone);
        int st = m_state();
        int tot = m_total();
        bit eok = 1'b0;
        bit xok = 1'b0;
        if (ent_valid && st == 1 && ez < NZ && tot < MAXC) begin
            if (m_occ[ez] < cap_of(ez, m_hq)) eok = 1'b1;
        end
        if (ext_valid && xz < NZ) begin
            if (m_occ[xz] > 0) xok = 1'b1;
        end
        if (eok) m_occ[ez]++;
        if (xok) m_occ[xz]--;
        if (ent_valid && !eok && m_rej < 65535) m_rej++;
        m_eack  = (ent_valid && eok)  ? 1 : 0;
        m_enack = (ent_valid && !eok) ? 1 : 0;
        m_xack  = (ext_valid && xok)  ? 1 : 0;
        m_xnack = (ext_valid && !xok) ? 1 : 0;
        m_hq = int'(hour);
    endtask

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ent_ack", int'(ent_ack), m_eack);
            check("ent_nack", int'(ent_nack), m_enack);
            check("ext_ack", int'(ext_ack), m_xack);
            check("ext_nack", int'(ext_nack), m_xnack);
            for (int z = 0; z < NZ; z++) begin
                check($sformatf("occupied[%0d]", z), d_occ(z), m_occ[z]);
                check($sformatf("vacant[%0d]", z), d_vac(z), m_vac(z));
                check($sformatf("zone_avail[%0d]", z), int'(zone_avail[z]), (m_vac(z) != 0) ? 1 : 0);
            end
            check("total_occ", int'(total_occ), m_total());
            check("reject_cnt", int'(reject_cnt), m_rej);
            check("state", int'(state), m_state());
        end
    end

    task automatic tick();
        @(posedge clk);
        if (start) model_step();
        @(negedge clk);
        #1;
        cycle++;
    endtask

    task automatic idle(input int n);
        ent_valid = 1'b0;
        ext_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic enter(input int z);
        ent_valid = 1'b1; ent_zone = 2'(z); ext_valid = 1'b0;
        tick();
        ent_valid = 1'b0;
    endtask

    task automatic leave(input int z);
        ext_valid = 1'b1; ext_zone = 2'(z); ent_valid = 1'b0;
        tick();
        ext_valid = 1'b0;
    endtask

    int n_ack, n_nack;
    int hours_tab [7] = '{7, 9, 12, 13, 14, 15, 17};

    initial begin
        model_reset();
        repeat (2) tick();
        chk_en = 1'b1;
        tick();
        check("reset_state", int'(state), 0);
        check("reset_total", int'(total_occ), 0);
        check("reset_vacant0", d_vac(0), 0);

        // Closed hours: entry rejected
        start = 1'b1; hour = 12'd7;
        idle(1);
        enter(0);
        check("closed_nack", int'(ent_nack), 1);
        check("closed_occ0", d_occ(0), 0);
        check("closed_state", int'(state), 0);
        check("closed_rej", int'(reject_cnt), 1);
        check("model_rej", m_rej, 1);

        // Fill public zone to its 200 capacity, one more is rejected
        hour = 12'd9;
        idle(1);
        n_ack = 0; n_nack = 0;
        ent_valid = 1'b1; ent_zone = 2'd1;
        repeat (201) begin
            tick();
            if (ent_ack) n_ack++;
            if (ent_nack) n_nack++;
        end
        ent_valid = 1'b0;
        check("z1_fill_acks", n_ack, 200);
        check("z1_fill_nacks", n_nack, 1);
        check("z1_last_nack", int'(ent_nack), 1);
        check("z1_vacant", d_vac(1), 0);
        check("z1_avail", int'(zone_avail[1]), 0);
        check("model_occ1", m_occ[1], 200);

        // Fill university zone, global limit reached
        n_ack = 0;
        ent_valid = 1'b1; ent_zone = 2'd0;
        repeat (500) begin
            tick();
            if (ent_ack) n_ack++;
        end
        ent_valid = 1'b0;
        check("z0_fill_acks", n_ack, 500);
        check("full_state", int'(state), 2);
        check("full_total", int'(total_occ), 700);
        enter(0);
        check("full_nack", int'(ent_nack), 1);
        leave(1);
        check("full_exit_ack", int'(ext_ack), 1);
        idle(1);
        check("reopen_state", int'(state), 1);

        // Full public zone with concurrent entry and exit on it
        enter(1);
        check("z1_refill_ack", int'(ent_ack), 1);
        ent_valid = 1'b1; ent_zone = 2'd1;
        ext_valid = 1'b1; ext_zone = 2'd1;
        tick();
        ent_valid = 1'b0; ext_valid = 1'b0;
        check("same_zone_ent_nack", int'(ent_nack), 1);
        check("same_zone_ext_ack", int'(ext_ack), 1);
        check("same_zone_occ1", d_occ(1), 199);

        // Capacity drop below occupancy
        repeat (50) leave(0);
        check("z0_at_450", d_occ(0), 450);
        hour = 12'd16;
        #1;
        check("cap_lag_vacant0", d_vac(0), 50);
        tick();
        check("cap_drop_vacant0", d_vac(0), 0);
        check("cap_drop_occ0", d_occ(0), 450);
        leave(0);
        check("cap_drop_exit_occ0", d_occ(0), 449);
        check("cap_drop_exit_vac0", d_vac(0), 0);
        check("model_vac0", m_vac(0), 0);

        // Empty zone and out-of-range zone ids
        leave(2);
        check("empty_exit_nack", int'(ext_nack), 1);
        enter(3);
        check("bad_zone_ent_nack", int'(ent_nack), 1);
        leave(3);
        check("bad_zone_ext_nack", int'(ext_nack), 1);
        check("bad_zone_total", int'(total_occ), 648);

        // Auxiliary zone capacity
        n_ack = 0;
        for (int i = 0; i < 5; i++) begin
            enter(2);
            if (ent_ack) n_ack++;
        end
        check("aux_acks", n_ack, 4);
        check("aux_last_nack", int'(ent_nack), 1);
        check("aux_vacant", d_vac(2), 0);

        // Randomised traffic with hour changes and mid-traffic resets
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) hour = HW'(hours_tab[$urandom_range(0, 6)]);
            ent_valid = ($urandom_range(0, 9) < 6);
            ent_zone  = 2'($urandom_range(0, 3));
            ext_valid = ($urandom_range(0, 9) < 5);
            ext_zone  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 599) == 0) begin
                #2;
                start = 1'b0;
                model_reset();
                repeat (2) tick();
                #2;
                start = 1'b1;
            end
            tick();
        end

        idle(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
